transpose_sched: RTL and testbench
==================================

TRANSPOSE_SCHED -- requirements
Module: transpose_sched

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 8, giving the number of elements per transpose FIFO.
REQ-002 The block SHALL have the parameter NUM_FIFO, default 8, giving the number of transpose FIFOs sequenced (one per array column).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have the port start, input, 1 bit: requests a new load/run pass.
REQ-006 The block SHALL have the port ld_valid, input, 1 bit: the producer has a row for the current FIFO.
REQ-007 The block SHALL have the port ld_ready, output, 1 bit: the block accepts a row this cycle.
REQ-008 The block SHALL have the port wr_en, output, NUM_FIFO bits: per-FIFO load strobe (drives FIFO WrEn).
REQ-009 The block SHALL have the port fifo_en, output, NUM_FIFO bits: per-FIFO shift enable (drives FIFO en).
REQ-010 The block SHALL have the port col_valid, output, NUM_FIFO bits: FIFO k's q holds a real element this cycle.
REQ-011 The block SHALL have the port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have the port done, output, 1 bit: one-cycle pulse at the end of a pass.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-014 IDLE -> LOAD SHALL occur on the cycle after start=1; start in any state other than IDLE SHALL be ignored.
REQ-015 LOAD: ld_ready=1; a 0..NUM_FIFO-1 counter ld_cnt, zeroed on entry, selects the target FIFO.
REQ-016 In LOAD, an accepted beat (ld_valid & ld_ready) SHALL assert wr_en[ld_cnt] combinationally in the same cycle and increment ld_cnt; wr_en SHALL be one-hot or zero, and zero outside LOAD.
REQ-017 ld_valid=0 in LOAD SHALL stall with no strobe, no counter change and no timeout.
REQ-018 The accept at ld_cnt=NUM_FIFO-1 SHALL move to RUN next cycle with run counter c=0.
REQ-019 RUN SHALL last exactly DEPTH+NUM_FIFO-1 cycles, c=0..DEPTH+NUM_FIFO-2, counter width $clog2(DEPTH+NUM_FIFO).
REQ-020 In RUN, col_valid[k] SHALL equal fifo_en[k], which SHALL be 1 iff k <= c < k+DEPTH (diagonal skew: element j of FIFO k presented at c=k+j, shifted out the same cycle).
REQ-021 Each FIFO SHALL receive exactly DEPTH shift pulses per pass; fifo_en and col_valid SHALL be 0 outside RUN.
REQ-022 After c=DEPTH+NUM_FIFO-2, the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-023 start asserted while in DONE SHALL be ignored; a new pass requires start in IDLE.
REQ-024 Latency: start accepted at cycle t with zero-stall loading gives first fifo_en at t+1+NUM_FIFO and done at t+1+NUM_FIFO+DEPTH+NUM_FIFO-1.
REQ-025 DEPTH=1 and NUM_FIFO=1 SHALL be legal: RUN is then a single cycle with only fifo_en[0]=1.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE and zero ld_cnt and c from any state, including mid-LOAD and mid-RUN.
REQ-027 While rst_n=0, and in the first cycle after release, ld_ready, wr_en, fifo_en, col_valid, busy and done SHALL be 0.
REQ-028 A pass interrupted by reset SHALL NOT resume; the next pass starts with start.
REQ-029 The block SHALL NOT generate a FIFO reset; FIFO contents left by an aborted pass are overwritten by the next LOAD.

Verification
REQ-030 Defaults, start pulse, ld_valid held 1: the bench SHALL check wr_en=01,02,04,...,80 on 8 consecutive cycles, then 15 RUN cycles, then done high for 1 cycle, then busy=0.
REQ-031 RUN skew check: the bench SHALL check fifo_en=01 at c=0, FF at c=7, FE at c=8 and 80 at c=14, and that each bit is high for exactly 8 cycles.
REQ-032 Load stall: the bench SHALL drop ld_valid for 3 cycles after the 4th beat and check wr_en=0, ld_cnt held, and the RUN start shifted by 3 cycles.
REQ-033 Reset at RUN c=5: the bench SHALL check that all outputs are 0 on the next cycle, that the block stays IDLE without start, and that a fresh pass completes normally.
REQ-034 With 8 transpose FIFOs loaded with rows 1..64, the bench SHALL check that column k sees values k*8+1..k*8+8 on cycles c=k..k+7 and 0 otherwise.
REQ-035 The bench SHALL check that start asserted during LOAD, RUN and DONE has no effect, and that done occurs exactly once per pass.

Source files
------------

// File: rtl/transpose_sched.sv
// transpose_sched: sequences a bank of transpose FIFOs through one pass.
// A pass loads one row per FIFO (LOAD), then shifts all FIFOs out with a
// diagonal skew so column k starts k cycles after column 0 (RUN), then
// pulses done for one cycle (DONE) and returns to IDLE.
//
// Handshake: a row beat transfers on a rising edge where ld_valid and
// ld_ready are both high; ld_valid may drop at any time to stall loading,
// and the block never times out a stalled load.
module transpose_sched #(
  parameter int DEPTH    = 8,
  parameter int NUM_FIFO = 8,
  localparam int LDW     = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1,
  localparam int CW      = $clog2(DEPTH + NUM_FIFO)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ld_valid,
  output logic                ld_ready,
  output logic [NUM_FIFO-1:0] wr_en,
  output logic [NUM_FIFO-1:0] fifo_en,
  output logic [NUM_FIFO-1:0] col_valid,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg,
  output logic [LDW-1:0]      ld_cnt_dbg,
  output logic [CW-1:0]       run_cnt_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LDW-1:0] LD_LAST  = LDW'(NUM_FIFO - 1);
  localparam logic [CW-1:0]  RUN_LAST = CW'(DEPTH + NUM_FIFO - 2);

  state_t         state, state_nxt;
  logic [LDW-1:0] ld_cnt, ld_cnt_nxt;
  logic [CW-1:0]  run_cnt, run_cnt_nxt;
  logic           accept;

  // State and counter registers; reset aborts any pass in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ld_cnt  <= '0;
      run_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ld_cnt  <= ld_cnt_nxt;
      run_cnt <= run_cnt_nxt;
    end
  end

  assign accept = (state == S_LOAD) && ld_valid;

  // Next-state and counter update: start only counts in IDLE, loading
  // advances one FIFO per accepted beat, RUN spans DEPTH+NUM_FIFO-1 cycles.
  always_comb begin
    state_nxt   = state;
    ld_cnt_nxt  = ld_cnt;
    run_cnt_nxt = run_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_LOAD;
          ld_cnt_nxt = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (ld_cnt == LD_LAST) begin
            state_nxt   = S_RUN;
            run_cnt_nxt = '0;
          end else begin
            ld_cnt_nxt = ld_cnt + LDW'(1);
          end
        end
      end
      S_RUN: begin
        if (run_cnt == RUN_LAST) begin
          state_nxt = S_DONE;
        end else begin
          run_cnt_nxt = run_cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: one-hot load strobe and the diagonal shift window.
  always_comb begin
    ld_ready = (state == S_LOAD);
    wr_en    = '0;
    fifo_en  = '0;
    if (accept) begin
      wr_en = NUM_FIFO'(1) << ld_cnt;
    end
    for (int k = 0; k < NUM_FIFO; k++) begin
      fifo_en[k] = (state == S_RUN) &&
                   (int'(run_cnt) >= k) &&
                   (int'(run_cnt) < k + DEPTH);
    end
    col_valid = fifo_en;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
  end

  assign state_dbg   = state;
  assign ld_cnt_dbg  = ld_cnt;
  assign run_cnt_dbg = run_cnt;

endmodule

// File: tb/tb_transpose_sched.sv
// Bench for transpose_sched: cycle-timeline reference model plus directed
// passes (plain pass, load stall, reset mid-RUN, data skew, ignored start)
// and a DEPTH=1/NUM_FIFO=1 corner instance.
module tb_transpose_sched;

  localparam int DEPTH = 8;
  localparam int NF    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, ld_valid = 1'b0;
  logic       ld_ready, busy, done;
  logic [7:0] wr_en, fifo_en, col_valid;
  logic [1:0] state_dbg;
  logic [2:0] ld_cnt_dbg;
  logic [3:0] run_cnt_dbg;

  logic       start1 = 1'b0, ld_valid1 = 1'b0;
  logic       ld_ready1, busy1, done1;
  logic [0:0] wr_en1, fifo_en1, col_valid1;
  logic [1:0] state_dbg1;
  logic [0:0] ld_cnt_dbg1, run_cnt_dbg1;

  transpose_sched #(.DEPTH(DEPTH), .NUM_FIFO(NF)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .wr_en(wr_en), .fifo_en(fifo_en),
    .col_valid(col_valid), .busy(busy), .done(done),
    .state_dbg(state_dbg), .ld_cnt_dbg(ld_cnt_dbg), .run_cnt_dbg(run_cnt_dbg)
  );

  transpose_sched #(.DEPTH(1), .NUM_FIFO(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ld_valid(ld_valid1),
    .ld_ready(ld_ready1), .wr_en(wr_en1), .fifo_en(fifo_en1),
    .col_valid(col_valid1), .busy(busy1), .done(done1),
    .state_dbg(state_dbg1), .ld_cnt_dbg(ld_cnt_dbg1), .run_cnt_dbg(run_cnt_dbg1)
  );

  // ---------------- check bookkeeping ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (timeline of a pass) ----------------
  int now       = 0;   // index of the current clock cycle
  bit m_load    = 0;   // pass is collecting rows
  int m_beats   = 0;   // rows accepted so far in this pass
  int m_run_t0  = -1;  // cycle index where shifting starts, -1 if none
  int m_done_t  = -1;  // cycle index of the done pulse

  function automatic bit m_running();
    return m_run_t0 >= 0;
  endfunction

  function automatic int m_c();
    return now - m_run_t0;
  endfunction

  function automatic bit m_busy();
    return m_load || m_running() || (now == m_done_t);
  endfunction

  // Transpose FIFO models fed by the DUT strobes (sampled at the negedge).
  int         mem [NF][DEPTH];
  int         rd  [NF];
  logic [7:0] wr_en_s = '0, fifo_en_s = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_load   = 0;
      m_run_t0 = -1;
      m_done_t = -1;
    end else if (m_load) begin
      if (ld_valid) begin
        if (m_beats == NF - 1) begin
          m_load   = 0;
          m_run_t0 = now + 1;
        end else begin
          m_beats++;
        end
      end
    end else if (m_running()) begin
      if (m_c() == DEPTH + NF - 2) begin
        m_run_t0 = -1;
        m_done_t = now + 1;
      end
    end else if (now != m_done_t && start) begin
      m_load  = 1;
      m_beats = 0;
    end
    for (int k = 0; k < NF; k++) begin
      if (wr_en_s[k]) begin
        for (int j = 0; j < DEPTH; j++) mem[k][j] = k * DEPTH + j + 1;
        rd[k] = 0;
      end else if (fifo_en_s[k] && rd[k] < DEPTH - 1) begin
        rd[k]++;
      end
    end
    now++;
  end

  // ---------------- scoreboard / compare ----------------
  bit         cmp_en   = 0;
  bit         data_chk = 0;
  int         done_seen = 0;
  int         bitcnt [NF];
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    logic [7:0] e_wr, e_fe, col, e_col;
    if (cmp_en) begin
      e_wr = (m_load && ld_valid) ? 8'(1 << m_beats) : 8'h00;
      e_fe = '0;
      for (int k = 0; k < NF; k++)
        e_fe[k] = m_running() && (m_c() >= k) && (m_c() < k + DEPTH);
      check("ld_ready", ld_ready, m_load);
      check("wr_en", wr_en, e_wr);
      check("fifo_en", fifo_en, e_fe);
      check("col_valid", col_valid, e_fe);
      check("busy", busy, m_busy());
      check("done", done, now == m_done_t);
      if (data_chk) begin
        for (int k = 0; k < NF; k++) begin
          col = col_valid[k] ? 8'(mem[k][rd[k]]) : 8'h00;
          if (e_fe[k]) e_col = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
          else e_col = 8'h00;
          check("col_data", col, e_col);
        end
      end
      for (int k = 0; k < NF; k++) if (fifo_en[k]) bitcnt[k]++;
      if (done) begin
        done_seen++;
        for (int k = 0; k < NF; k++) check("fifo_en_pulses", bitcnt[k], DEPTH);
      end
      if (done || !rst_n) for (int k = 0; k < NF; k++) bitcnt[k] = 0;
    end
    wr_en_s   = wr_en;
    fifo_en_s = fifo_en;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 60) begin
      at_neg();
      if (done) seen = 1;
      step();
      n++;
    end
    check(name, seen, 1);
    at_neg();
    check({name, "_idle"}, busy, 0);
    step();
  endtask

  task automatic run_pass(input string name);
    done_seen = 0;
    start = 1; ld_valid = 1;
    step();
    start = 0;
    wait_done(name);
    ld_valid = 0;
    check({name, "_done_once"}, done_seen, 1);
  endtask

  logic [7:0] wr_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    int t0, n;
    bit found;
    for (int k = 0; k < NF; k++) begin
      bitcnt[k] = 0;
      rd[k] = 0;
      for (int j = 0; j < DEPTH; j++) mem[k][j] = 0;
    end

    // reset
    rst_n = 0;
    step();
    step();
    cmp_en = 1;
    at_neg();
    check("rst_outputs", {ld_ready, wr_en, fifo_en, col_valid, busy, done}, 0);
    step();
    rst_n = 1;
    at_neg();
    check("rst_release_outputs", {ld_ready, wr_en, fifo_en, col_valid, busy, done}, 0);
    step();

    // corner instance: DEPTH=1, NUM_FIFO=1
    start1 = 1; ld_valid1 = 1;
    step();
    start1 = 0;
    at_neg();
    check("d1_wr_en", {ld_ready1, wr_en1}, 2'b11);
    step();
    ld_valid1 = 0;
    at_neg();
    check("d1_run", {fifo_en1, col_valid1, busy1, done1}, 4'b1110);
    step();
    at_neg();
    check("d1_done", {fifo_en1, busy1, done1}, 3'b011);
    step();
    at_neg();
    check("d1_idle", {busy1, done1}, 2'b00);
    step();

    // plain pass with ld_valid held high
    done_seen = 0;
    start = 1; ld_valid = 1;
    at_neg();
    check("t1_idle_busy", busy, 0);
    step();
    start = 0;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      check("t1_wr_en", wr_en, wr_tab[i]);
      step();
    end
    for (int c = 0; c < 15; c++) begin
      at_neg();
      check("t1_run_busy", {busy, ld_ready, done}, 3'b100);
      if (c == 0)  check("t1_fe_c0", fifo_en, 8'h01);
      if (c == 7)  check("t1_fe_c7", fifo_en, 8'hFF);
      if (c == 8)  check("t1_fe_c8", fifo_en, 8'hFE);
      if (c == 14) check("t1_fe_c14", fifo_en, 8'h80);
      step();
      ld_valid = 0;
    end
    at_neg();
    check("t1_done", done, 1);
    step();
    at_neg();
    check("t1_after", {busy, done}, 2'b00);
    step();
    check("t1_done_once", done_seen, 1);

    // load stall after the 4th beat
    done_seen = 0;
    start = 1; ld_valid = 1;
    t0 = now;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) step();
    ld_valid = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("stall_wr_en", wr_en, 0);
      check("stall_ld_cnt", ld_cnt_dbg, 4);
      step();
    end
    ld_valid = 1;
    found = 0;
    n = 0;
    while (!found && n < 40) begin
      at_neg();
      if (fifo_en != 0) found = 1;
      else step();
      n++;
    end
    check("stall_run_start", now - t0, 12);
    step();
    ld_valid = 0;
    wait_done("stall_done");
    check("stall_done_once", done_seen, 1);

    // reset at RUN c=5
    done_seen = 0;
    start = 1; ld_valid = 1;
    step();
    start = 0;
    n = 0;
    while (!(m_running() && m_c() == 5) && n < 40) begin
      step();
      n++;
    end
    at_neg();
    check("rst_c5_fe", fifo_en, 8'h3F);
    rst_n = 0; ld_valid = 0;
    step();
    at_neg();
    check("rstrun_outputs", {ld_ready, wr_en, fifo_en, col_valid, busy, done}, 0);
    check("rstrun_state", state_dbg, 0);
    step();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("rstrun_stay_idle", busy, 0);
      step();
    end
    check("rstrun_no_done", done_seen, 0);
    run_pass("rstrun_fresh");

    // data skew: column k shows k*8+1..k*8+8 on c=k..k+7
    for (int c = 0; c < DEPTH + NF - 1; c++)
      for (int k = 0; k < NF; k++)
        if (c >= k && c < k + DEPTH) exp_q.push_back(8'(k * DEPTH + 1 + c - k));
    data_chk = 1;
    run_pass("data_pass");
    data_chk = 0;
    check("data_q_empty", exp_q.size(), 0);

    // start during LOAD, RUN and DONE is ignored
    done_seen = 0;
    start = 1; ld_valid = 1;
    step();
    start = 0;
    step();
    step();
    start = 1;
    step();
    start = 0;
    n = 0;
    while (!(m_running() && m_c() == 3) && n < 40) begin
      step();
      n++;
    end
    start = 1;
    step();
    start = 0;
    n = 0;
    while (now != m_done_t && n < 40) begin
      step();
      n++;
    end
    at_neg();
    check("ign_done", done, 1);
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("ign_idle", busy, 0);
      step();
    end
    ld_valid = 0;
    check("ign_done_once", done_seen, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
